// File: rtl/id_stage.sv
// Decode stage: IF/ID capture, opcode decode, registered ID/EX bundle.
// Owns the fetch stall for multi-cycle MUL and for the terminal HALT state.
module id_stage #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  if_pc,
  input  logic [19:0] if_instr,
  output logic        stall,
  output logic        ex_valid,
  output logic [7:0]  ex_pc,
  output logic [3:0]  ex_op,
  output logic [7:0]  ex_a,
  output logic [7:0]  ex_b,
  output logic        ex_is_mul,
  output logic        ex_illegal,
  output logic        halted,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HALTED} state_t;

  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 2);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [7:0]  ifid_pc_q, ifid_pc_d;
  logic [19:0] ifid_instr_q, ifid_instr_d;
  logic        ex_valid_q, ex_valid_d;
  logic [7:0]  ex_pc_q, ex_pc_d;
  logic [3:0]  ex_op_q, ex_op_d;
  logic [7:0]  ex_a_q, ex_a_d;
  logic [7:0]  ex_b_q, ex_b_d;
  logic        ex_is_mul_q, ex_is_mul_d;
  logic        ex_illegal_q, ex_illegal_d;
  logic        halted_q, halted_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [3:0]  ifid_op;
  logic        issue, issue_mul, issue_halt, op_legal, stall_int;

  always_comb begin
    ifid_op    = ifid_instr_q[19:16];
    issue      = ifid_valid_q && (state_q == S_IDLE);
    issue_mul  = issue && (ifid_op == OP_MUL);
    issue_halt = issue && (ifid_op == OP_HALT);
    op_legal   = (ifid_op <= 4'h9) || (ifid_op == OP_HALT);
    // Depends only on registered state, never on the fetch inputs.
    stall_int  = issue_mul || issue_halt || (state_q != S_IDLE);

    state_d      = state_q;
    cnt_d        = cnt_q;
    ifid_valid_d = 1'b0;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ex_valid_d   = 1'b0;
    ex_pc_d      = 8'h00;
    ex_op_d      = 4'h0;
    ex_a_d       = 8'h00;
    ex_b_d       = 8'h00;
    ex_is_mul_d  = 1'b0;
    ex_illegal_d = 1'b0;
    halted_d     = halted_q;
    err_cnt_d    = err_cnt_q;

    if (!stall_int) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = if_pc;
      ifid_instr_d = if_instr;
    end

    if (issue) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = ifid_pc_q;
      ex_op_d      = op_legal ? ifid_op : 4'h0;
      ex_a_d       = ifid_instr_q[15:8];
      ex_b_d       = ifid_instr_q[7:0];
      ex_is_mul_d  = issue_mul;
      ex_illegal_d = !op_legal;
      if (!op_legal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (issue_mul && (MUL_CYCLES > 2)) begin
          state_d = S_BUSY;
          cnt_d   = MUL_INIT;
        end else if (issue_halt) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) state_d = S_IDLE;
        cnt_d = cnt_q - 4'd1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 8'h00;
      ifid_instr_q <= 20'h00000;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= 8'h00;
      ex_op_q      <= 4'h0;
      ex_a_q       <= 8'h00;
      ex_b_q       <= 8'h00;
      ex_is_mul_q  <= 1'b0;
      ex_illegal_q <= 1'b0;
      halted_q     <= 1'b0;
      err_cnt_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_op_q      <= ex_op_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_is_mul_q  <= ex_is_mul_d;
      ex_illegal_q <= ex_illegal_d;
      halted_q     <= halted_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign stall      = stall_int;
  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_op      = ex_op_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_is_mul  = ex_is_mul_q;
  assign ex_illegal = ex_illegal_q;
  assign halted     = halted_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: three instances (MUL_CYCLES 2,3,4) fed by a simple fetch
// model, checked against an expected EX slot stream built from the program.
module tb_id_stage;

  localparam int NDUT = 3;
  localparam int SLOTS = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  if_pc_w      [NDUT];
  logic [19:0] if_instr_w   [NDUT];
  logic        stall_w      [NDUT];
  logic        ex_valid_w   [NDUT];
  logic [7:0]  ex_pc_w      [NDUT];
  logic [3:0]  ex_op_w      [NDUT];
  logic [7:0]  ex_a_w       [NDUT];
  logic [7:0]  ex_b_w       [NDUT];
  logic        ex_is_mul_w  [NDUT];
  logic        ex_illegal_w [NDUT];
  logic        halted_w     [NDUT];
  logic [7:0]  err_cnt_w    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    id_stage #(.MUL_CYCLES(g + 2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .if_pc     (if_pc_w[g]),
      .if_instr  (if_instr_w[g]),
      .stall     (stall_w[g]),
      .ex_valid  (ex_valid_w[g]),
      .ex_pc     (ex_pc_w[g]),
      .ex_op     (ex_op_w[g]),
      .ex_a      (ex_a_w[g]),
      .ex_b      (ex_b_w[g]),
      .ex_is_mul (ex_is_mul_w[g]),
      .ex_illegal(ex_illegal_w[g]),
      .halted    (halted_w[g]),
      .err_cnt   (err_cnt_w[g])
    );
  end

  logic [19:0] prog [256];
  // Expected per edge n: EX bundle after edge n, stall during the cycle before it.
  logic [30:0] exp_bund  [NDUT][SLOTS];
  logic        exp_stall [NDUT][SLOTS];
  logic        exp_halt  [NDUT][SLOTS];
  logic [7:0]  exp_err   [NDUT][SLOTS];
  logic [7:0]  fpc [NDUT];
  logic        s_prev [NDUT];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] obs_bund(input int k);
    return {ex_valid_w[k], ex_is_mul_w[k], ex_illegal_w[k], ex_pc_w[k],
            ex_op_w[k], ex_a_w[k], ex_b_w[k]};
  endfunction

  task automatic put_slot(input int k, input int n, input logic [30:0] b, input logic s,
                          input logic h, input logic [7:0] e);
    if (n < SLOTS) begin
      exp_bund[k][n]  = b;
      exp_stall[k][n] = s;
      exp_halt[k][n]  = h;
      exp_err[k][n]   = e;
    end
  endtask

  // Architectural view: every instruction appears once, in program order;
  // a MUL is followed by C-1 bubbles (stall drops for the last one), a HALT by bubbles forever.
  task automatic build_expected(input int k, input int ncyc);
    int c, n, i;
    logic h;
    logic [7:0] e;
    logic [19:0] ins;
    logic [3:0] op;
    logic legal;
    c = k + 2;
    n = 1;
    h = 1'b0;
    e = 8'd0;
    i = 0;
    put_slot(k, 1, 31'd0, 1'b0, 1'b0, 8'd0);
    while (n < ncyc + 2) begin
      ins = prog[i % 256];
      op = ins[19:16];
      legal = (op <= 4'h9) || (op == 4'hF);
      if (!legal && e != 8'd255) e = e + 8'd1;
      if (op == 4'hF) h = 1'b1;
      n++;
      put_slot(k, n, {1'b1, op == 4'h8, !legal, 8'(i), legal ? op : 4'h0, ins[15:8], ins[7:0]},
               (op == 4'h8) || (op == 4'hF), h, e);
      if (op == 4'h8) begin
        for (int b = 1; b < c; b++) begin
          n++;
          put_slot(k, n, 31'd0, b != c - 1, h, e);
        end
      end
      if (op == 4'hF) begin
        while (n < ncyc + 2) begin
          n++;
          put_slot(k, n, 31'd0, 1'b1, h, e);
        end
      end
      i++;
    end
  endtask

  task automatic check_zero(input string where);
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("%s_bundle[%0d]", where, k), 32'(obs_bund(k)), 32'd0);
      check_eq($sformatf("%s_stall[%0d]", where, k), 32'(stall_w[k]), 32'd0);
      check_eq($sformatf("%s_halted[%0d]", where, k), 32'(halted_w[k]), 32'd0);
      check_eq($sformatf("%s_err[%0d]", where, k), 32'(err_cnt_w[k]), 32'd0);
    end
  endtask

  task automatic run(input string name, input int ncyc);
    for (int k = 0; k < NDUT; k++) begin
      build_expected(k, ncyc);
      fpc[k] = 8'd0;
      if_pc_w[k] = 8'd0;
      if_instr_w[k] = prog[0];
    end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero({name, "_rst"});
    rstn = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("%s_stall[%0d]@0", name, k), 32'(stall_w[k]), 32'(exp_stall[k][1]));
      s_prev[k] = stall_w[k];
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check_eq($sformatf("%s_ex[%0d]@%0d", name, k, c), 32'(obs_bund(k)), 32'(exp_bund[k][c]));
        check_eq($sformatf("%s_halted[%0d]@%0d", name, k, c), 32'(halted_w[k]), 32'(exp_halt[k][c]));
        check_eq($sformatf("%s_err[%0d]@%0d", name, k, c), 32'(err_cnt_w[k]), 32'(exp_err[k][c]));
        if (!s_prev[k]) fpc[k] = fpc[k] + 8'd1;
        if_pc_w[k] = fpc[k];
        if_instr_w[k] = prog[fpc[k]];
        check_eq($sformatf("%s_stall[%0d]@%0d", name, k, c), 32'(stall_w[k]), 32'(exp_stall[k][c + 1]));
        s_prev[k] = stall_w[k];
      end
    end
  endtask

  task automatic fill_nops;
    for (int i = 0; i < 256; i++) prog[i] = {4'h0, 8'(i), 8'(255 - i)};
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      if_pc_w[k] = 8'd0;
      if_instr_w[k] = 20'd0;
    end

    // Directed stream: ADD, SUB, MUL, ADD, illegal, HALT @pc5.
    fill_nops();
    prog[0] = 20'h10503;
    prog[1] = 20'h20904;
    prog[2] = 20'h80304;
    prog[3] = 20'h10102;
    prog[4] = 20'hB1122;
    prog[5] = 20'hF0000;
    run("directed", 40);

    // MUL immediately followed by HALT.
    fill_nops();
    prog[0] = 20'h80506;
    prog[1] = 20'hF0000;
    run("mulhalt", 20);

    // Back-to-back MULs.
    fill_nops();
    for (int i = 0; i < 4; i++) prog[i] = {4'h8, 8'(i), 8'h07};
    run("mulmul", 24);

    // Random programs with occasional HALT.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 256; i++) begin
        prog[i][15:0] = 16'($urandom);
        prog[i][19:16] = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      end
      run($sformatf("rand%0d", r), 100);
    end

    // Saturation of the illegal-opcode counter.
    for (int i = 0; i < 256; i++) prog[i] = {4'($urandom_range(10, 14)), 16'($urandom)};
    run("illegal", 310);
    for (int k = 0; k < NDUT; k++)
      check_eq($sformatf("err_sat[%0d]", k), 32'(err_cnt_w[k]), 32'd255);

    // Asynchronous reset while BUSY with a nonzero error count.
    fill_nops();
    prog[0] = 20'hC0000;
    prog[1] = 20'h80203;
    run("prereset", 3);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    #1;
    rstn = 1'b1;

    // Restart after reset: PC 0 must issue on the 2nd edge.
    fill_nops();
    prog[0] = 20'h30F0A;
    run("restart", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
